// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 byte router.
// Channel count, default width and sel encodings.
package demux_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int NCH       = 4;

  typedef enum logic [1:0] {
    SEL_CH0 = 2'b00,
    SEL_CH1 = 2'b01,
    SEL_CH2 = 2'b10,
    SEL_CH3 = 2'b11
  } sel_e;

  function automatic logic [NCH-1:0] sel_onehot(
    input logic [1:0] s
  );
    logic [NCH-1:0] r;
    r = '0;
    unique case (1'b1)
      (s == SEL_CH0): r = 4'b0001;
      (s == SEL_CH1): r = 4'b0010;
      (s == SEL_CH2): r = 4'b0100;
      (s == SEL_CH3): r = 4'b1000;
      default:        r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/demux_1_4_router_if.sv
// Input handshake plus four output channels.
// master = producer/consumers, slave = router.
interface demux_1_4_router_if
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic [WIDTH-1:0] in_data;
  logic [1:0]       sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic [NCH-1:0]   out_valid;
  logic [NCH-1:0]   out_ready;

  modport master (
    output in_data,
    output sel,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out0,
    input  out1,
    input  out2,
    input  out3,
    input  out_valid
  );

  modport slave (
    input  in_data,
    input  sel,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out0,
    output out1,
    output out2,
    output out3,
    output out_valid
  );

endinterface

// File: rtl/demux_slot.sv
// One-entry channel buffer: load wins over drain,
// so a same-cycle drain+load keeps valid high.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= din;
      valid <= 1'b1;
    end else if (valid && drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1_4_router.sv
// 1-to-4 byte router with per-channel one-entry buffers.
// DEMUX_COUNT_EN adds per-channel transfer counters (cnt).
module demux_1_4_router
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  demux_1_4_router_if.slave   bus
`ifdef DEMUX_COUNT_EN
  ,
  output logic [31:0]         cnt
`endif
);

  logic [WIDTH-1:0] data [NCH];
  logic [NCH-1:0]   valid;
  logic [NCH-1:0]   load;
  logic             accept;

  assign bus.in_ready = ~valid[bus.sel]
                      | bus.out_ready[bus.sel];
  assign accept = bus.in_valid & bus.in_ready;
  assign load   = accept ? sel_onehot(bus.sel)
                         : '0;

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .drain (bus.out_ready[k]),
      .din   (bus.in_data),
      .data  (data[k]),
      .valid (valid[k])
    );
  end

  assign bus.out0      = data[0];
  assign bus.out1      = data[1];
  assign bus.out2      = data[2];
  assign bus.out3      = data[3];
  assign bus.out_valid = valid;

`ifdef DEMUX_COUNT_EN
  logic [NCH-1:0] fire;
  logic [31:0]    cnt_q;

  assign fire = valid & bus.out_ready;

  // 8-bit lanes wrap naturally at 255
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (fire[k])
          cnt_q[k*8 +: 8] <= cnt_q[k*8 +: 8] + 8'd1;
      end
    end
  end

  assign cnt = cnt_q;
`endif

endmodule

// File: tb/tb_demux_1_4_router.sv
// Directed table-driven bench for demux_1_4_router.
// Build with DEMUX_COUNT_EN to also check cnt.
module tb_demux_1_4_router;

  logic clk;
  logic rst_n;

  demux_1_4_router_if #(.WIDTH(8)) bus ();

`ifdef DEMUX_COUNT_EN
  logic [31:0] cnt;
`endif

  demux_1_4_router #(
    .WIDTH (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef DEMUX_COUNT_EN
    ,
    .cnt   (cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] d;
    logic [1:0] s;
    logic       v;
    logic [3:0] ordy;
    logic       crdy;
    logic       erdy;
    logic [3:0] eov;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [7:0] e2;
    logic [7:0] e3;
  } vec_t;

  vec_t vt [19];
  int n_cmp;
  int n_bad;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input logic r,
                       input logic [7:0] d,
                       input logic [1:0] s,
                       input logic v,
                       input logic [3:0] o);
    rst_n         = r;
    bus.in_data   = d;
    bus.sel       = s;
    bus.in_valid  = v;
    bus.out_ready = o;
  endtask

  function automatic vec_t mk(
    input logic r, input logic [7:0] d,
    input logic [1:0] s, input logic v,
    input logic [3:0] o, input logic cr,
    input logic er, input logic [3:0] ev,
    input logic [7:0] a, input logic [7:0] b,
    input logic [7:0] c, input logic [7:0] e);
    vec_t t;
    t.rst = r;  t.d = d;  t.s = s;
    t.v = v;    t.ordy = o;
    t.crdy = cr; t.erdy = er; t.eov = ev;
    t.e0 = a; t.e1 = b; t.e2 = c; t.e3 = e;
    return t;
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    drive(1'b0, 8'h00, 2'b00, 1'b0, 4'h0);

    // rst d s v ordy crdy erdy eov out0..3
    vt[0]  = mk(0,8'hFF,0,1,4'b0000,0,0,4'b0000,8'h00,8'h00,8'h00,8'h00);
    vt[1]  = mk(1,8'h00,0,0,4'b0000,1,1,4'b0000,8'h00,8'h00,8'h00,8'h00);
    vt[2]  = mk(1,8'hA5,2,1,4'b0000,1,1,4'b0100,8'h00,8'h00,8'hA5,8'h00);
    vt[3]  = mk(1,8'h00,2,0,4'b0000,1,0,4'b0100,8'h00,8'h00,8'hA5,8'h00);
    vt[4]  = mk(1,8'h00,2,0,4'b0100,1,1,4'b0000,8'h00,8'h00,8'hA5,8'h00);
    vt[5]  = mk(1,8'h11,1,1,4'b0000,1,1,4'b0010,8'h00,8'h11,8'hA5,8'h00);
    vt[6]  = mk(1,8'h22,1,1,4'b0000,1,0,4'b0010,8'h00,8'h11,8'hA5,8'h00);
    vt[7]  = mk(1,8'h22,3,1,4'b0000,1,1,4'b1010,8'h00,8'h11,8'hA5,8'h22);
    vt[8]  = mk(1,8'h00,0,0,4'b1010,1,1,4'b0000,8'h00,8'h11,8'hA5,8'h22);
    vt[9]  = mk(1,8'h01,0,1,4'b0001,1,1,4'b0001,8'h01,8'h11,8'hA5,8'h22);
    vt[10] = mk(1,8'h02,0,1,4'b0001,1,1,4'b0001,8'h02,8'h11,8'hA5,8'h22);
    vt[11] = mk(1,8'h03,0,1,4'b0001,1,1,4'b0001,8'h03,8'h11,8'hA5,8'h22);
    vt[12] = mk(1,8'h04,0,1,4'b0001,1,1,4'b0001,8'h04,8'h11,8'hA5,8'h22);
    vt[13] = mk(1,8'h00,0,0,4'b0001,1,1,4'b0000,8'h04,8'h11,8'hA5,8'h22);
    vt[14] = mk(1,8'h55,0,1,4'b0000,1,1,4'b0001,8'h55,8'h11,8'hA5,8'h22);
    vt[15] = mk(1,8'h7E,3,1,4'b0001,1,1,4'b1000,8'h55,8'h11,8'hA5,8'h7E);
    vt[16] = mk(1,8'h00,3,0,4'b0000,1,0,4'b1000,8'h55,8'h11,8'hA5,8'h7E);
    vt[17] = mk(0,8'h99,1,1,4'b0000,1,1,4'b0000,8'h00,8'h00,8'h00,8'h00);
    vt[18] = mk(1,8'hEE,2,0,4'b0000,1,1,4'b0000,8'h00,8'h00,8'h00,8'h00);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vt[i].rst, vt[i].d, vt[i].s,
            vt[i].v, vt[i].ordy);
      #1;
      if (vt[i].crdy)
        chk($sformatf("v%0d in_ready", i),
            32'(bus.in_ready), 32'(vt[i].erdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i),
          32'(bus.out_valid), 32'(vt[i].eov));
      chk($sformatf("v%0d out0", i),
          32'(bus.out0), 32'(vt[i].e0));
      chk($sformatf("v%0d out1", i),
          32'(bus.out1), 32'(vt[i].e1));
      chk($sformatf("v%0d out2", i),
          32'(bus.out2), 32'(vt[i].e2));
      chk($sformatf("v%0d out3", i),
          32'(bus.out3), 32'(vt[i].e3));
    end

    // stalled ch2 must hold its byte while inputs churn
    @(negedge clk);
    drive(1'b1, 8'hC3, 2'b10, 1'b1, 4'b0000);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1'b1, 8'(8'h30 + i), 2'b10, 1'b1,
            4'b1011);
      #1;
      chk($sformatf("stall%0d in_ready", i),
          32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d out2", i),
          32'(bus.out2), 32'h0000_00C3);
      chk($sformatf("stall%0d out_valid", i),
          32'(bus.out_valid), 32'b0100);
    end
    @(negedge clk);
    drive(1'b1, 8'h00, 2'b00, 1'b0, 4'b0100);
    @(posedge clk);
    #1;
    chk("stall drain out_valid",
        32'(bus.out_valid), 32'd0);

`ifdef DEMUX_COUNT_EN
    @(negedge clk);
    drive(1'b0, 8'h00, 2'b00, 1'b0, 4'b0000);
    @(posedge clk);
    #1;
    chk("cnt reset", cnt, 32'd0);
    for (int i = 0; i < 257; i++) begin
      @(negedge clk);
      drive(1'b1, 8'(i), 2'b10, 1'b1, 4'b0100);
      @(posedge clk);
    end
    @(negedge clk);
    drive(1'b1, 8'h00, 2'b10, 1'b0, 4'b0100);
    @(posedge clk);
    #1;
    chk("cnt 257 on ch2", cnt, 32'h0001_0000);
    chk("cnt drained", 32'(bus.out_valid), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
